// File: rtl/dma_channel_arbiter_if.sv
// Request/grant bundle between the DMA request logic, the CPU hold pins and the arbiter.
// master = arbiter side, slave = request sources / CPU / timing control side.
interface dma_channel_arbiter_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]      DREQ;
    logic [NUM_CH-1:0]      softReq;
    logic [NUM_CH-1:0]      maskReg;
    logic                   priorityType;
    logic                   ctrlDisable;
    logic                   HLDA;
    logic                   serviceDone;
    logic                   HRQ;
    logic [NUM_CH-1:0]      DACK;
    logic                   assertDACK;
    logic [CH_W-1:0]        grantCh;
    logic [NUM_CH*CH_W-1:0] priorityOrder;

    modport master (
        input  DREQ, softReq, maskReg, priorityType, ctrlDisable, HLDA, serviceDone,
        output HRQ, DACK, assertDACK, grantCh, priorityOrder
    );

    modport slave (
        output DREQ, softReq, maskReg, priorityType, ctrlDisable, HLDA, serviceDone,
        input  HRQ, DACK, assertDACK, grantCh, priorityOrder
    );
endinterface

// File: rtl/dma_channel_arbiter.sv
// Four-channel DMA arbiter: picks a channel by fixed/rotating priority and runs HRQ/HLDA.
// Latency: HRQ one edge after a pending request, DACK one edge after HLDA; all outputs registered.
// Backpressure: none buffered; a grant is held until serviceDone or the CPU reclaims the bus.
module dma_channel_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    dma_channel_arbiter_if.master  bus
);
    localparam int CH_W = $clog2(NUM_CH);

    localparam logic [3:0] ST_IDLE    = 4'b0001;
    localparam logic [3:0] ST_REQ     = 4'b0010;
    localparam logic [3:0] ST_GRANT   = 4'b0100;
    localparam logic [3:0] ST_RELEASE = 4'b1000;

    logic [3:0]             state_q,  state_d;
    logic                   hrq_q,    hrq_d;
    logic [NUM_CH-1:0]      dack_q,   dack_d;
    logic                   assert_q, assert_d;
    logic [CH_W-1:0]        grant_q,  grant_d;
    logic [NUM_CH*CH_W-1:0] order_q,  order_d;

    logic [NUM_CH-1:0]      pending;
    logic [CH_W-1:0]        winner;
    logic [NUM_CH*CH_W-1:0] rotated;

    function automatic logic [NUM_CH*CH_W-1:0] reset_order();
        logic [NUM_CH*CH_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            v[i*CH_W +: CH_W] = CH_W'(i);
        end
        return v;
    endfunction

    assign pending = (bus.DREQ | bus.softReq) & ~bus.maskReg;

    // Walk ranks lowest to highest so the highest-ranked pending channel is written last.
    always_comb begin
        winner = order_q[CH_W-1:0];
        for (int r = NUM_CH - 1; r >= 0; r--) begin
            if (pending[order_q[r*CH_W +: CH_W]]) begin
                winner = order_q[r*CH_W +: CH_W];
            end
        end
    end

    // The channel just serviced drops to the lowest rank; the one after it becomes rank 0.
    always_comb begin
        rotated = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rotated[i*CH_W +: CH_W] = CH_W'((int'(grant_q) + 1 + i) % NUM_CH);
        end
    end

    always_comb begin
        state_d = state_q;
        hrq_d   = hrq_q;
        dack_d  = dack_q;
        grant_d = grant_q;
        order_d = order_q;

        // Priority mode changes are deferred while a grant is outstanding.
        if (state_q != ST_GRANT && !bus.priorityType) begin
            order_d = reset_order();
        end

        case (state_q)
            ST_IDLE: begin
                hrq_d  = 1'b0;
                dack_d = '0;
                if (pending != '0 && !bus.ctrlDisable) begin
                    state_d = ST_REQ;
                    hrq_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.HLDA && pending != '0) begin
                    state_d = ST_GRANT;
                    dack_d  = {{(NUM_CH-1){1'b0}}, 1'b1} << winner;
                    grant_d = winner;
                end else if (pending == '0) begin
                    state_d = ST_RELEASE;
                    hrq_d   = 1'b0;
                end
            end
            ST_GRANT: begin
                if (bus.serviceDone) begin
                    state_d = ST_RELEASE;
                    hrq_d   = 1'b0;
                    dack_d  = '0;
                    if (bus.priorityType) begin
                        order_d = rotated;
                    end
                end else if (!bus.HLDA) begin
                    state_d = ST_RELEASE;
                    hrq_d   = 1'b0;
                    dack_d  = '0;
                end
            end
            ST_RELEASE: begin
                hrq_d  = 1'b0;
                dack_d = '0;
                if (!bus.HLDA) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hrq_d   = 1'b0;
                dack_d  = '0;
            end
        endcase

        assert_d = |dack_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            hrq_q    <= 1'b0;
            dack_q   <= '0;
            assert_q <= 1'b0;
            grant_q  <= '0;
            order_q  <= reset_order();
        end else begin
            state_q  <= state_d;
            hrq_q    <= hrq_d;
            dack_q   <= dack_d;
            assert_q <= assert_d;
            grant_q  <= grant_d;
            order_q  <= order_d;
        end
    end

    assign bus.HRQ           = hrq_q;
    assign bus.DACK          = dack_q;
    assign bus.assertDACK    = assert_q;
    assign bus.grantCh       = grant_q;
    assign bus.priorityOrder = order_q;
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed and randomized checks of dma_channel_arbiter against a rank-list reference model.
module tb_dma_channel_arbiter;
    localparam int N = 4;
    localparam int W = 2;

    logic CLK = 1'b0;
    logic RESET;

    dma_channel_arbiter_if #(.NUM_CH(N)) bus();

    dma_channel_arbiter #(.NUM_CH(N)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.master)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 asking for bus, 2 servicing, 3 handing bus back.
    int m_phase;
    bit m_hrq;
    bit m_busy;
    int m_ch;
    int m_rank[N];
    bit auto_hlda;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] exp_order();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_rank[i]);
        return v;
    endfunction

    task automatic model_step();
        logic [N-1:0] pend;
        int nphase, nch;
        bit nhrq, nbusy;
        int nrank[N];
        pend = (bus.DREQ | bus.softReq) & ~bus.maskReg;
        if (RESET) begin
            m_phase = 0; m_hrq = 0; m_busy = 0; m_ch = 0;
            for (int i = 0; i < N; i++) m_rank[i] = i;
            return;
        end
        nphase = m_phase; nhrq = m_hrq; nbusy = m_busy; nch = m_ch;
        for (int i = 0; i < N; i++) nrank[i] = m_rank[i];
        if (m_phase != 2 && !bus.priorityType)
            for (int i = 0; i < N; i++) nrank[i] = i;
        case (m_phase)
            0: if (pend != 0 && !bus.ctrlDisable) begin nphase = 1; nhrq = 1; end
            1: begin
                if (bus.HLDA && pend != 0) begin
                    nphase = 2; nbusy = 1; nch = -1;
                    for (int r = 0; r < N; r++)
                        if (nch < 0 && pend[m_rank[r]]) nch = m_rank[r];
                end else if (pend == 0) begin
                    nphase = 3; nhrq = 0;
                end
            end
            2: begin
                if (bus.serviceDone || !bus.HLDA) begin
                    nphase = 3; nbusy = 0; nhrq = 0;
                    if (bus.serviceDone && bus.priorityType)
                        for (int i = 0; i < N; i++) nrank[i] = (m_ch + 1 + i) % N;
                end
            end
            default: if (!bus.HLDA) nphase = 0;
        endcase
        m_phase = nphase; m_hrq = nhrq; m_busy = nbusy; m_ch = nch;
        for (int i = 0; i < N; i++) m_rank[i] = nrank[i];
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_dack;
        exp_dack = '0;
        if (m_busy) exp_dack[m_ch] = 1'b1;
        chk("HRQ", 32'(bus.HRQ), 32'(m_hrq));
        chk("DACK", 32'(bus.DACK), 32'(exp_dack));
        chk("assertDACK", 32'(bus.assertDACK), 32'(m_busy));
        if (m_busy) chk("grantCh", 32'(bus.grantCh), 32'(m_ch));
        chk("priorityOrder", 32'(bus.priorityOrder), 32'(exp_order()));
        chk("inv_onehot", 32'($onehot0(bus.DACK)), 32'd1);
        if (bus.DACK != 0) chk("inv_hrq", 32'(bus.HRQ), 32'd1);
        chk("inv_assert", 32'(bus.assertDACK), 32'(|bus.DACK));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check_outputs();
        if (auto_hlda) bus.HLDA = m_hrq;
    endtask

    task automatic wait_grant();
        for (int k = 0; k < 30; k++) begin
            if (bus.assertDACK) break;
            tick();
        end
        chk("grant_timeout", 32'(bus.assertDACK), 32'd1);
    endtask

    task automatic serve(input string tag, input logic [N-1:0] exp);
        wait_grant();
        chk(tag, 32'(bus.DACK), 32'(exp));
        bus.serviceDone = 1'b1;
        tick();
        bus.serviceDone = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        auto_hlda = 1'b0;
        bus.DREQ = '0; bus.softReq = '0; bus.maskReg = '0;
        bus.priorityType = 1'b0; bus.ctrlDisable = 1'b0;
        bus.HLDA = 1'b0; bus.serviceDone = 1'b0;
        m_phase = 0; m_hrq = 0; m_busy = 0; m_ch = 0;
        for (int i = 0; i < N; i++) m_rank[i] = i;

        tick(); tick();
        chk("reset_hrq", 32'(bus.HRQ), 32'd0);
        chk("reset_dack", 32'(bus.DACK), 32'd0);
        chk("reset_grant", 32'(bus.grantCh), 32'd0);
        chk("reset_order", 32'(bus.priorityOrder), 32'h0E4);

        // Fixed priority, HLDA high throughout.
        RESET = 1'b0;
        bus.HLDA = 1'b1;
        bus.DREQ = 4'b1110;
        tick();
        chk("t1_hrq", 32'(bus.HRQ), 32'd1);
        tick();
        chk("t1_dack", 32'(bus.DACK), 32'b0010);
        auto_hlda = 1'b1;
        bus.serviceDone = 1'b1;
        tick();
        bus.serviceDone = 1'b0;

        // Fixed priority with every channel requesting: channel 0 always wins.
        bus.DREQ = 4'b1111;
        for (int s = 0; s < 3; s++) begin
            serve("t2_dack", 4'b0001);
            chk("t2_order", 32'(bus.priorityOrder), 32'h0E4);
        end

        // Rotating priority.
        bus.priorityType = 1'b1;
        serve("t3_dack0", 4'b0001);
        chk("t3_order", 32'(bus.priorityOrder), 32'h039);
        serve("t3_dack1", 4'b0010);
        serve("t3_dack2", 4'b0100);
        serve("t3_dack3", 4'b1000);
        bus.DREQ = '0;
        bus.priorityType = 1'b0;
        repeat (4) tick();

        // ctrlDisable holds off a new request.
        bus.ctrlDisable = 1'b1;
        bus.DREQ = 4'b0001;
        repeat (3) begin
            tick();
            chk("t_dis_hrq", 32'(bus.HRQ), 32'd0);
        end
        bus.ctrlDisable = 1'b0;
        tick();
        chk("t_dis_release", 32'(bus.HRQ), 32'd1);
        bus.DREQ = '0;
        repeat (4) tick();

        // Masked request, then unmask and delay HLDA.
        auto_hlda = 1'b0;
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b0100;
        bus.maskReg = 4'b0100;
        repeat (3) begin
            tick();
            chk("t4_masked_hrq", 32'(bus.HRQ), 32'd0);
        end
        bus.maskReg = '0;
        tick();
        chk("t4_hrq", 32'(bus.HRQ), 32'd1);
        repeat (4) tick();
        bus.HLDA = 1'b1;
        tick();
        chk("t4_dack", 32'(bus.DACK), 32'b0100);

        // No pre-emption; CPU reclaims the bus.
        bus.DREQ = 4'b0101;
        tick();
        chk("t5_hold", 32'(bus.DACK), 32'b0100);
        bus.HLDA = 1'b0;
        tick();
        chk("t5_drop_dack", 32'(bus.DACK), 32'd0);
        chk("t5_order", 32'(bus.priorityOrder), 32'h0E4);
        chk("t5_hrq_low", 32'(bus.HRQ), 32'd0);
        tick();
        chk("t5_hrq_low2", 32'(bus.HRQ), 32'd0);
        tick();
        chk("t5_rereq", 32'(bus.HRQ), 32'd1);
        bus.HLDA = 1'b1;
        auto_hlda = 1'b1;
        serve("t5_ch0", 4'b0001);
        bus.DREQ = '0;
        repeat (3) tick();

        // Reset in the middle of a grant.
        bus.priorityType = 1'b1;
        bus.DREQ = 4'b0010;
        serve("t6_ch1", 4'b0010);
        bus.DREQ = 4'b1000;
        wait_grant();
        chk("t6_grant3", 32'(bus.DACK), 32'b1000);
        RESET = 1'b1;
        tick();
        chk("t6_rst_hrq", 32'(bus.HRQ), 32'd0);
        chk("t6_rst_dack", 32'(bus.DACK), 32'd0);
        chk("t6_rst_order", 32'(bus.priorityOrder), 32'h0E4);
        RESET = 1'b0;
        serve("t6_rearb", 4'b1000);

        // Randomized traffic against the model.
        auto_hlda = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bus.DREQ    = 4'($urandom);
            bus.softReq = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            bus.maskReg = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 49) == 0) bus.priorityType = ~bus.priorityType;
            bus.ctrlDisable = ($urandom_range(0, 9) == 0);
            bus.HLDA = ($urandom_range(0, 9) == 0) ? 1'($urandom) : m_hrq;
            bus.serviceDone = m_busy && ($urandom_range(0, 3) == 0);
            RESET = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
